// File: rtl/condlogic_mc.sv
// Condition unit for the multicycle ARM datapath.
// Holds the architectural {N,Z,C,V} flag register and evaluates the instruction
// condition field against it. The result is registered for one cycle and then
// gates the controller's PC, register-file and memory write strobes.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-high reset
//   Cond     - instruction condition field Instr[31:28]
//   ALUFlags - ALU flags {N,Z,C,V} for the current Execute cycle
//   FlagW    - flag write enables: [1] writes {N,Z}, [0] writes {C,V}
//   PCS      - instruction writes the PC
//   NextPC   - unconditional PC update (fetch)
//   RegW     - register write request
//   MemW     - memory write request
//   PCWrite  - gated PC enable (combinational)
//   RegWrite - gated register-file write enable (combinational)
//   MemWrite - gated memory write enable (combinational)
//   Flags    - current flag register {N,Z,C,V}
//   CondEx   - combinational condition result against the current Flags
module condlogic_mc #(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondEx
);

    localparam int unsigned FLAG_W = 4;

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    logic              cond_ex_q;
    logic              cond_ex_c;

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Condition decode, always against the registered flags.
    always_comb begin
        cond_ex_c = 1'b0;
        unique case (Cond)
            4'h0:    cond_ex_c = flag_z;
            4'h1:    cond_ex_c = ~flag_z;
            4'h2:    cond_ex_c = flag_c;
            4'h3:    cond_ex_c = ~flag_c;
            4'h4:    cond_ex_c = flag_n;
            4'h5:    cond_ex_c = ~flag_n;
            4'h6:    cond_ex_c = flag_v;
            4'h7:    cond_ex_c = ~flag_v;
            4'h8:    cond_ex_c = flag_c & ~flag_z;
            4'h9:    cond_ex_c = ~flag_c | flag_z;
            4'hA:    cond_ex_c = ~(flag_n ^ flag_v);
            4'hB:    cond_ex_c = flag_n ^ flag_v;
            4'hC:    cond_ex_c = ~flag_z & ~(flag_n ^ flag_v);
            4'hD:    cond_ex_c = flag_z | (flag_n ^ flag_v);
            default: cond_ex_c = 1'b1;
        endcase
    end

    // Independent half-writes of the flag register; a failed condition writes nothing.
    always_comb begin
        flags_d = flags_q;
        if (FlagW[1] && cond_ex_c) begin
            flags_d[3:2] = ALUFlags[3:2];
        end
        if (FlagW[0] && cond_ex_c) begin
            flags_d[1:0] = ALUFlags[1:0];
        end
    end

    // Flag register and one-cycle delayed condition result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q   <= FLAGS_RST;
            cond_ex_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_c;
        end
    end

    // Strobe gating; NextPC forces a PC update regardless of the condition.
    assign PCWrite  = (PCS & cond_ex_q) | NextPC;
    assign RegWrite = RegW & cond_ex_q;
    assign MemWrite = MemW & cond_ex_q;
    assign Flags    = flags_q;
    assign CondEx   = cond_ex_c;

endmodule

// File: doc/condlogic_mc.md
Name: condlogic_mc

Overview:
- Condition unit for the multicycle ARM datapath. It sits directly downstream of the ALU and consumes its 4-bit {N,Z,C,V} flag vector.
- Holds the architectural flag register and evaluates the 4-bit instruction condition field against it.
- Registers the condition result for one cycle and gates the controller's PC, register-file and memory write strobes with it.

Parameters:
- FLAGS_RST, 4'b0000, value loaded into the flag register {N,Z,C,V} on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  ALU flags {N,Z,C,V} for the current Execute cycle.
- FlagW  input  2  flag write enables. Bit 1 writes {N,Z}; bit 0 writes {C,V}.
- PCS  input  1  instruction writes PC (branch, or Rd==R15).
- NextPC  input  1  unconditional PC update from the controller FSM (fetch).
- RegW  input  1  register write request from the controller FSM.
- MemW  input  1  memory write request from the controller FSM.
- PCWrite  output  1  gated PC enable.
- RegWrite  output  1  gated register-file write enable.
- MemWrite  output  1  gated memory write enable.
- Flags  output  4  current flag register {N,Z,C,V}.
- CondEx  output  1  combinational condition result against the current Flags.

Behaviour:
- Reset (asynchronous):
  - Flags <= FLAGS_RST and CondExR <= 0, immediately and independent of clk.
  - While reset is asserted: RegWrite=0, MemWrite=0, PCWrite=NextPC.
- Condition evaluation is combinational on the registered Flags, never on ALUFlags:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: 1 (unconditional)
- Flag register writes, on the rising edge:
  - If FlagW[1] & CondEx: Flags[3:2] <= ALUFlags[3:2].
  - If FlagW[0] & CondEx: Flags[1:0] <= ALUFlags[1:0].
  - The two halves are independent; an unwritten half holds its value.
  - A failed condition writes no flags.
- CondExR: registered copy of CondEx, loaded every cycle. It is one cycle of latency, so the decision taken in Execute is applied in the following ALUWB/MemWrite/Branch cycle.
- Output gating (combinational):
  - PCWrite = (PCS & CondExR) | NextPC
  - RegWrite = RegW & CondExR
  - MemWrite = MemW & CondExR
- Simultaneous flag write and evaluation: CondEx in a given cycle uses the pre-update Flags. The new flags are visible from the next cycle.
- NextPC overrides the condition: PCWrite=1 whenever NextPC=1, regardless of CondExR.
- Reset mid-instruction: any pending write is cancelled because CondExR is cleared. The next instruction sees FLAGS_RST.
- There are no illegal states. All 16 Cond encodings are defined.

Test Plan:
- Reset while Flags=4'b1111 -> Flags=4'b0000 and CondExR=0 before the next clk edge. With RegW=1, RegWrite=0.
- Cond=E, FlagW=2'b11, ALUFlags=4'b0100, one edge -> Flags=4'b0100. Next cycle: Cond=0 gives CondEx=1; Cond=1 gives CondEx=0.
- Flags=4'b0000, FlagW=2'b10, ALUFlags=4'b1111 -> Flags=4'b1100 (C,V held). Then FlagW=2'b01, ALUFlags=4'b0011 -> Flags=4'b1111.
- Flags=4'b0100, Cond=1 (NE), FlagW=2'b11, ALUFlags=4'b1010 -> Flags unchanged 4'b0100. Next cycle: RegW=1, MemW=1 -> RegWrite=0, MemWrite=0.
- Flags=4'b1001 (N=1, V=1), Cond=A (GE) -> CondEx=1; Cond=B (LT) -> CondEx=0. With GE and PCS=1, PCWrite=1 one cycle later.
- NextPC=1 while CondExR=0 and PCS=0 -> PCWrite=1. Also sweep all 16 Cond values × 16 Flags values against a reference model.
